// File: rtl/kr580_pkg.sv
// Shared constants for the KR580VV55-lite parallel interface: register addresses,
// control-word bit positions and the power-on control word.
package kr580_pkg;

  localparam logic [1:0] REG_PA   = 2'd0;
  localparam logic [1:0] REG_PB   = 2'd1;
  localparam logic [1:0] REG_PC   = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_MODESET = 7;
  localparam int CTRL_PA_IN   = 4;
  localparam int CTRL_PCH_IN  = 3;
  localparam int CTRL_PB_IN   = 1;
  localparam int CTRL_PCL_IN  = 0;

  // All ports input, mode 0.
  localparam logic [7:0] DEF_RESET_CTRL = 8'h9B;

endpackage

// File: rtl/sync_bus.sv
// Clock-enable gated multi-bit synchroniser; pins appear at q after STAGES ce cycles.
module sync_bus #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/kr580vv55_lite.sv
// KR580VV55 / i8255 subset: mode 0 ports A/B/C plus port C bit set/reset, with a
// registered read path that is valid one ce cycle after the read strobe.
module kr580vv55_lite
  import kr580_pkg::*;
#(
  parameter logic [7:0] RESET_CTRL  = DEF_RESET_CTRL,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       cs,
  input  logic [1:0] a,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic       pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic       pb_oe,
  input  logic [7:0] pc_in,
  output logic [7:0] pc_out,
  output logic [1:0] pc_oe
);

  logic [7:0] ctrl;
  logic [7:0] pa_latch, pb_latch, pc_latch;
  logic [7:0] pa_sync, pb_sync, pc_sync;
  logic [7:0] dout_reg;
  logic [7:0] rd_data;
  logic       do_write, do_read;

  sync_bus #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_pa (
    .clock(clock), .reset_n(reset_n), .ce(ce), .d(pa_in), .q(pa_sync)
  );
  sync_bus #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_pb (
    .clock(clock), .reset_n(reset_n), .ce(ce), .d(pb_in), .q(pb_sync)
  );
  sync_bus #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_pc (
    .clock(clock), .reset_n(reset_n), .ce(ce), .d(pc_in), .q(pc_sync)
  );

  assign do_write = ce && cs && wr;
  assign do_read  = ce && cs && rd && !wr;

  always_comb begin
    rd_data = ctrl;
    case (a)
      REG_PA:   rd_data = ctrl[CTRL_PA_IN] ? pa_sync : pa_latch;
      REG_PB:   rd_data = ctrl[CTRL_PB_IN] ? pb_sync : pb_latch;
      REG_PC: begin
        rd_data[7:4] = ctrl[CTRL_PCH_IN] ? pc_sync[7:4] : pc_latch[7:4];
        rd_data[3:0] = ctrl[CTRL_PCL_IN] ? pc_sync[3:0] : pc_latch[3:0];
      end
      default:  rd_data = ctrl;
    endcase
  end

  // Latches are written regardless of direction; oe alone decides whether pins are driven.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl     <= RESET_CTRL;
      pa_latch <= 8'h00;
      pb_latch <= 8'h00;
      pc_latch <= 8'h00;
    end else if (do_write) begin
      case (a)
        REG_PA: pa_latch <= din;
        REG_PB: pb_latch <= din;
        REG_PC: pc_latch <= din;
        default: begin
          if (din[CTRL_MODESET]) begin
            ctrl     <= din;
            pa_latch <= 8'h00;
            pb_latch <= 8'h00;
            pc_latch <= 8'h00;
          end else begin
            pc_latch[din[3:1]] <= din[0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dout_reg <= 8'hFF;
    end else if (do_read) begin
      dout_reg <= rd_data;
    end
  end

  assign dout   = dout_reg;
  assign pa_out = pa_latch;
  assign pb_out = pb_latch;
  assign pc_out = pc_latch;
  assign pa_oe  = ~ctrl[CTRL_PA_IN];
  assign pb_oe  = ~ctrl[CTRL_PB_IN];
  assign pc_oe  = {~ctrl[CTRL_PCH_IN], ~ctrl[CTRL_PCL_IN]};

endmodule

// File: tb/tb_kr580vv55_lite.sv
// Bench for kr580vv55_lite: directed scenarios then randomized bus traffic, every
// cycle compared against a behavioural model of the i8255 mode-0 subset.
module tb_kr580vv55_lite;

  logic       clock = 1'b0;
  logic       reset_n, ce, cs, wr, rd;
  logic [1:0] a;
  logic [7:0] din, dout;
  logic [7:0] pa_in, pa_out, pb_in, pb_out, pc_in, pc_out;
  logic       pa_oe, pb_oe;
  logic [1:0] pc_oe;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  kr580vv55_lite #(.RESET_CTRL(8'h9B), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .cs(cs), .a(a), .wr(wr), .rd(rd),
    .din(din), .dout(dout),
    .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
    .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe),
    .pc_in(pc_in), .pc_out(pc_out), .pc_oe(pc_oe)
  );

  // Reference state: control word, port latches, read register, and pin history
  // (front of each queue is what a read on this ce cycle sees).
  logic [7:0] m_ctrl, m_pa, m_pb, m_pc, m_dout;
  logic [7:0] hist_a[$], hist_b[$], hist_c[$];

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 8'h9B;
    m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00;
    m_dout = 8'hFF;
    hist_a = '{8'h00, 8'h00};
    hist_b = '{8'h00, 8'h00};
    hist_c = '{8'h00, 8'h00};
  endtask

  task automatic model_edge();
    logic [7:0] va, vb, vc, rv;
    if (!reset_n) begin
      model_reset();
    end else if (ce) begin
      va = hist_a[0]; vb = hist_b[0]; vc = hist_c[0];
      case (a)
        2'd0:    rv = m_ctrl[4] ? va : m_pa;
        2'd1:    rv = m_ctrl[1] ? vb : m_pb;
        2'd2:    rv = {m_ctrl[3] ? vc[7:4] : m_pc[7:4], m_ctrl[0] ? vc[3:0] : m_pc[3:0]};
        default: rv = m_ctrl;
      endcase
      if (cs && rd && !wr) m_dout = rv;
      if (cs && wr) begin
        case (a)
          2'd0: m_pa = din;
          2'd1: m_pb = din;
          2'd2: m_pc = din;
          default: begin
            if (din[7]) begin
              m_ctrl = din; m_pa = 8'h00; m_pb = 8'h00; m_pc = 8'h00;
            end else begin
              m_pc = din[0] ? (m_pc | (8'h01 << din[3:1])) : (m_pc & ~(8'h01 << din[3:1]));
            end
          end
        endcase
      end
      void'(hist_a.pop_front()); hist_a.push_back(pa_in);
      void'(hist_b.pop_front()); hist_b.push_back(pb_in);
      void'(hist_c.pop_front()); hist_c.push_back(pc_in);
    end
  endtask

  task automatic compare_all();
    check("dout",   dout,   m_dout);
    check("pa_out", pa_out, m_pa);
    check("pb_out", pb_out, m_pb);
    check("pc_out", pc_out, m_pc);
    check("pa_oe",  {7'd0, pa_oe}, {7'd0, ~m_ctrl[4]});
    check("pb_oe",  {7'd0, pb_oe}, {7'd0, ~m_ctrl[1]});
    check("pc_oe",  {6'd0, pc_oe}, {6'd0, ~m_ctrl[3], ~m_ctrl[0]});
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic bus(input logic w, input logic r, input logic [1:0] addr, input logic [7:0] d);
    ce = 1'b1; cs = 1'b1; wr = w; rd = r; a = addr; din = d;
    step();
    wr = 1'b0; rd = 1'b0; cs = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
    a = 2'd0; din = 8'h00; pa_in = 8'h00; pb_in = 8'h00; pc_in = 8'h00;
    model_reset();
    #2;
    step();
    step();
    reset_n = 1'b1;

    // 1: reset state, latch written while port is input
    check("rst_dout", dout, 8'hFF);
    bus(1'b0, 1'b1, 2'd3, 8'h00);
    check("rst_ctrl", dout, 8'h9B);
    bus(1'b1, 1'b0, 2'd0, 8'h55);
    check("pa_in_latch", pa_out, 8'h55);
    check("pa_in_noe", {7'd0, pa_oe}, 8'h00);

    // 2: mode set clears latches, PA output readback
    bus(1'b1, 1'b0, 2'd3, 8'h82);
    check("m82_pcoe", {6'd0, pc_oe}, 8'h03);
    check("m82_pa_clr", pa_out, 8'h00);
    bus(1'b1, 1'b0, 2'd0, 8'hA5);
    bus(1'b0, 1'b1, 2'd0, 8'h00);
    check("pa_read", dout, 8'hA5);

    // 3: synchroniser latency on PB
    pb_in = 8'h3C;
    ce = 1'b1;
    step();
    step();
    bus(1'b0, 1'b1, 2'd1, 8'h00);
    check("pb_sync", dout, 8'h3C);
    pb_in = 8'hC3;
    bus(1'b0, 1'b1, 2'd1, 8'h00);
    check("pb_latency", dout, 8'h3C);

    // 4: split port C
    bus(1'b1, 1'b0, 2'd3, 8'h8A);
    pc_in = 8'hF0;
    bus(1'b1, 1'b0, 2'd2, 8'h05);
    step();
    bus(1'b0, 1'b1, 2'd2, 8'h00);
    check("pc_split", dout, 8'hF5);

    // 5: bit set/reset
    bus(1'b1, 1'b0, 2'd3, 8'h0F);
    check("bsr_set7", pc_out, 8'h85);
    bus(1'b1, 1'b0, 2'd3, 8'h0E);
    check("bsr_clr7", pc_out, 8'h05);
    bus(1'b1, 1'b0, 2'd3, 8'h07);
    check("bsr_set3", pc_out, 8'h0D);
    bus(1'b0, 1'b1, 2'd3, 8'h00);
    check("bsr_ctrl", dout, 8'h8A);

    // 6: no ce, then reset during a read; wr+rd together
    ce = 1'b0; cs = 1'b1; wr = 1'b1; rd = 1'b1; a = 2'd3; din = 8'h80;
    step();
    check("noce_pc", pc_out, 8'h0D);
    check("noce_dout", dout, 8'h8A);
    bus(1'b1, 1'b1, 2'd1, 8'h77);
    check("wrrd_pb", pb_out, 8'h77);
    check("wrrd_dout", dout, 8'h8A);
    ce = 1'b1; cs = 1'b1; rd = 1'b1; a = 2'd0; reset_n = 1'b0;
    step();
    check("rst_mid_dout", dout, 8'hFF);
    reset_n = 1'b1; rd = 1'b0; cs = 1'b0;
    bus(1'b0, 1'b1, 2'd3, 8'h00);
    check("rst_mid_ctrl", dout, 8'h9B);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      ce      = ($urandom_range(0, 3) != 0);
      cs      = ($urandom_range(0, 4) != 0);
      a       = 2'($urandom_range(0, 3));
      wr      = ($urandom_range(0, 2) == 0);
      rd      = ($urandom_range(0, 1) == 0);
      din     = 8'($urandom);
      if (a == 2'd3 && wr && $urandom_range(0, 3) != 0) din[7] = 1'b0;
      if ($urandom_range(0, 2) == 0) pa_in = 8'($urandom);
      if ($urandom_range(0, 2) == 0) pb_in = 8'($urandom);
      if ($urandom_range(0, 2) == 0) pc_in = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
